// File: rtl/imem_resp_pkg.sv
// Shared fetch-side definitions: default widths and the responder FSM encoding.
package imem_resp_pkg;
    localparam int ADDR_L_DEF = 32;
    localparam int INST_L_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        ERR  = 2'd3
    } resp_state_e;
endpackage

// File: rtl/imem_store.sv
// Instruction word array: synchronous write, combinational read (old data on same-edge collision).
module imem_store
    import imem_resp_pkg::*;
#(
    parameter int INST_L   = INST_L_DEF,
    parameter int DEPTH_LG = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DEPTH_LG-1:0] waddr,
    input  logic [INST_L-1:0]   wdata,
    input  logic [DEPTH_LG-1:0] raddr,
    output logic [INST_L-1:0]   rdata
);
    logic [INST_L-1:0] mem [2**DEPTH_LG];

    // No reset: program contents survive rst.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_resp.sv
// Instruction fetch responder: validates a word-aligned pc, then streams the word LSB first.
module imem_resp
    import imem_resp_pkg::*;
#(
    parameter int ADDR_L   = ADDR_L_DEF,
    parameter int INST_L   = INST_L_DEF,
    parameter int DEPTH_LG = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_L-1:0]   req_addr,
    output logic                bit_out,
    output logic                bit_valid,
    input  logic                bit_ready,
    output logic                bit_last,
    output logic                resp_err,
    input  logic                ld_we,
    input  logic [DEPTH_LG-1:0] ld_addr,
    input  logic [INST_L-1:0]   ld_data
);
    localparam int CNT_W = $clog2(INST_L);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INST_L - 1);

    resp_state_e         state, state_nxt;
    logic [DEPTH_LG-1:0] idx;
    logic [INST_L-1:0]   shreg, rd_word;
    logic [CNT_W-1:0]    cnt;
    logic                accept, addr_bad, fire;

    assign accept   = req_valid & req_ready;
    assign fire     = bit_valid & bit_ready;
    assign addr_bad = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_L-1:DEPTH_LG+2] != '0);

    imem_store #(.INST_L(INST_L), .DEPTH_LG(DEPTH_LG)) u_store (
        .clk   (clk),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        bit_last  = 1'b0;
        resp_err  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = addr_bad ? ERR : LOAD;
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                bit_valid = 1'b1;
                bit_out   = shreg[0];
                bit_last  = (cnt == CNT_LAST);
                if (bit_ready && bit_last) state_nxt = IDLE;
            end
            ERR: begin
                resp_err  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register is a private snapshot, so later store writes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (accept && !addr_bad) idx <= req_addr[DEPTH_LG+1:2];
            if (state == LOAD) begin
                shreg <= rd_word;
                cnt   <= '0;
            end else if (fire) begin
                shreg <= shreg >> 1;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: checks timing, error handling, backpressure and store coherency.
module tb_imem_resp;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, bit_out, bit_valid, bit_ready, bit_last, resp_err;
    logic [31:0] req_addr, ld_data;
    logic        ld_we;
    logic [7:0]  ld_addr;

    int n_cmp = 0;
    int n_err = 0;

    imem_resp dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_last(bit_last),
        .resp_err(resp_err), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    // Issue one request from IDLE and advance to the cycle where the first bit should be valid.
    task automatic request(input logic [31:0] a);
        req_valid = 1'b1; req_addr = a;
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    // Collect 32 bits starting in the first SEND cycle; toggle=1 starts with bit_ready low.
    task automatic recv(input bit toggle, output logic [31:0] w, output int cycles, output int bad);
        int k;
        k = 0; cycles = 0; bad = 0; w = '0;
        while (k < 32 && cycles < 200) begin
            bit_ready = toggle ? ((cycles % 2) == 1) : 1'b1;
            if (!bit_valid) bad++;
            if (bit_valid && bit_ready) begin
                w[k] = bit_out;
                if (bit_last !== (k == 31)) bad++;
                k++;
            end
            tick();
            cycles++;
        end
        bit_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        int cyc, bad, nacc, first_acc, second_acc;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; bit_ready = 1'b1;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_bit_outs", {29'd0, bit_out, bit_last, resp_err}, 32'd0);

        // Basic fetch of word 0
        load_word(8'd0, 32'h8C220004);
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        chk("load_no_valid", 32'(bit_valid), 32'd0);
        chk("load_not_ready", 32'(req_ready), 32'd0);
        tick();
        chk("first_valid_acc2", 32'(bit_valid), 32'd1);
        recv(1'b0, w, cyc, bad);
        chk("w0_value", w, 32'h8C220004);
        chk("w0_cycles", cyc, 32'd32);
        chk("w0_last_valid", bad, 32'd0);
        chk("w0_ready_after", 32'(req_ready), 32'd1);
        chk("w0_valid_after", 32'(bit_valid), 32'd0);

        // Misaligned and out-of-range requests
        req_valid = 1'b1; req_addr = 32'h6;
        tick();
        req_valid = 1'b0;
        chk("err6_pulse", {30'd0, resp_err, bit_valid}, 32'd2);
        tick();
        chk("err6_done", {29'd0, resp_err, bit_valid, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = 32'h400;
        tick();
        req_valid = 1'b0;
        chk("err400_pulse", {30'd0, resp_err, bit_valid}, 32'd2);
        tick();
        chk("err400_done", {29'd0, resp_err, bit_valid, req_ready}, 32'd1);

        // Backpressure: bit_ready alternating
        load_word(8'd3, 32'hFFFF0000);
        request(32'hC);
        recv(1'b1, w, cyc, bad);
        chk("w3_value", w, 32'hFFFF0000);
        chk("w3_cycles", cyc, 32'd64);
        chk("w3_last_valid", bad, 32'd0);

        // Store write during SEND must not alter the in-flight word
        load_word(8'd5, 32'h12345678);
        request(32'h14);
        bit_ready = 1'b0;
        load_word(8'd5, 32'h0);
        recv(1'b0, w, cyc, bad);
        chk("w5_inflight", w, 32'h12345678);
        tick();
        request(32'h14);
        recv(1'b0, w, cyc, bad);
        chk("w5_rewritten", w, 32'h0);

        // Write in the LOAD cycle to the same index returns the old word
        load_word(8'd6, 32'hA5A5A5A5);
        req_valid = 1'b1; req_addr = 32'h18;
        tick();
        req_valid = 1'b0;
        ld_we = 1'b1; ld_addr = 8'd6; ld_data = 32'h5A5A5A5A;
        tick();
        ld_we = 1'b0;
        recv(1'b0, w, cyc, bad);
        chk("w6_rbw_old", w, 32'hA5A5A5A5);
        request(32'h18);
        recv(1'b0, w, cyc, bad);
        chk("w6_rbw_new", w, 32'h5A5A5A5A);

        // Reset mid-transfer, with a store write in the reset cycle
        request(32'h0);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1; ld_we = 1'b1; ld_addr = 8'd7; ld_data = 32'hDEADBEEF;
        tick();
        rst = 1'b0; ld_we = 1'b0;
        chk("rstmid_valid", 32'(bit_valid), 32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        tick();
        chk("rstmid_still_idle", 32'(bit_valid), 32'd0);
        request(32'h0);
        recv(1'b0, w, cyc, bad);
        chk("rstmid_refetch", w, 32'h8C220004);
        chk("rstmid_refetch_ok", bad, 32'd0);
        request(32'h1C);
        recv(1'b0, w, cyc, bad);
        chk("rst_cycle_write", w, 32'hDEADBEEF);

        // req_valid held: accepts only in IDLE, every 34 cycles
        bit_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        nacc = 0; first_acc = -1; second_acc = -1;
        for (int c = 0; c < 100; c++) begin
            if (req_valid && req_ready) begin
                if (nacc == 0) first_acc = c;
                if (nacc == 1) second_acc = c;
                nacc++;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("b2b_accepts", nacc, 32'd3);
        chk("b2b_period", second_acc - first_acc, 32'd34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter ADDR_L, default 32, meaning the fetch byte-address width.
REQ-002 SHALL have parameter INST_L, default 32, meaning the instruction word width and the serial bit count per fetch.
REQ-003 SHALL have parameter DEPTH_LG, default 8, meaning log2 of the word depth of the instruction store (256 words).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1, fetch request present.
REQ-007 SHALL have port req_ready, output, 1, responder able to accept a request.
REQ-008 SHALL have port req_addr, input, ADDR_L, the fetch byte address (the fetch stage's pc).
REQ-009 SHALL have port bit_out, output, 1, serial instruction bit, LSB first.
REQ-010 SHALL have port bit_valid, output, 1, bit_out is meaningful.
REQ-011 SHALL have port bit_ready, input, 1, the fetch stage consumes bit_out this cycle.
REQ-012 SHALL have port bit_last, output, 1, the current bit is bit INST_L-1.
REQ-013 SHALL have port resp_err, output, 1, a one-cycle pulse flagging a rejected request.
REQ-014 SHALL have ports ld_we (input, 1), ld_addr (input, DEPTH_LG) and ld_data (input, INST_L), forming the program-load write port.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, LOAD, SEND, ERR.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both high.
REQ-017 SHALL move from IDLE to ERR on accept when req_addr[1:0]!=0 or req_addr[ADDR_L-1:DEPTH_LG+2]!=0.
REQ-018 SHALL, in ERR, drive resp_err=1 for exactly one cycle, emit no bits, then return to IDLE.
REQ-019 SHALL, on a valid accept, latch word index req_addr[DEPTH_LG+1:2] and move to LOAD.
REQ-020 SHALL, in LOAD, copy the addressed word into a shift register, clear the bit counter and move to SEND, so the first bit_valid appears 2 cycles after accept.
REQ-021 SHALL, in SEND, hold bit_valid=1 with bit_out = shift register bit 0.
REQ-022 SHALL shift right and increment the counter only on cycles where bit_valid and bit_ready are both high; while bit_ready=0, bit_out and the counter SHALL hold.
REQ-023 SHALL assert bit_last when counter==INST_L-1; when that bit is consumed, the FSM SHALL return to IDLE and req_ready SHALL be 1 on the next cycle.
REQ-024 SHALL, when ld_we=1, write ld_data to ld_addr at the clock edge, in any state.
REQ-025 SHALL give the old contents when LOAD reads the same index that ld_we writes in the same cycle (read-before-write).
REQ-026 SHALL not let a write to the in-flight word alter bits already latched in the shift register.
REQ-027 SHALL ignore req_valid outside IDLE; no requests are queued.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE with req_ready=1 and bit_valid=0, bit_last=0, bit_out=0, resp_err=0, and the counter cleared.
REQ-029 SHALL, on reset during SEND or LOAD, abort the transfer without emitting a further bit.
REQ-030 SHALL not clear instruction store contents on reset; an ld_we in the reset cycle SHALL still take effect.

Structure
REQ-031 SHALL take ADDR_L/INST_L defaults and the FSM state encoding from the shared MIPS64 package also used by the fetch stage.
REQ-032 SHALL implement the store as one sub-module, imem_store: a synchronous-write, read-before-write word array; the FSM and shifter SHALL stay in imem_resp.

Verification
REQ-033 SHALL cover: load word 0 = 0x8C220004, request addr 0x0, bit_ready=1 -> first bit_valid at accept+2; 32 bits reassemble to 0x8C220004; bit_last on the 32nd bit; req_ready high on the following cycle.
REQ-034 SHALL cover: request addr 0x6 -> resp_err pulses 1 cycle, no bit_valid, req_ready back on the next cycle; request addr 0x400 -> same.
REQ-035 SHALL cover: word 3 = 0xFFFF0000, addr 0xC, bit_ready toggling 1/0 each cycle -> 32 bits delivered in 64 cycles, value 0xFFFF0000, no bit duplicated or dropped.
REQ-036 SHALL cover: during SEND of word 5 (=0x12345678), write word 5 = 0x0 -> the transfer still delivers 0x12345678, and the next fetch of 0x14 returns 0x0.
REQ-037 SHALL cover: rst asserted after 10 bits of a transfer -> bit_valid=0 the next cycle, req_ready=1, and a new request for word 0 delivers the correct full word.
REQ-038 SHALL cover: req_valid held high across back-to-back transfers -> requests are accepted only in IDLE, one per 34 cycles with bit_ready=1.
